// File: rtl/fetch_if.sv
// Control/status bundle between the decode/ALU side and the fetch unit.
// Master drives the decoded controls and LUT writes; slave returns PC and run status.
interface fetch_if #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int IDX_W = 4
);
    // Plain level signals sampled on every rising edge; there is no valid/ready
    // handshake, so each control is acted on in the cycle it is presented.
    logic             start;
    logic             halt;
    logic             branch_en;
    logic             branch_sel;
    logic [IDX_W-1:0] target_idx;
    logic             alu_overflow;
    logic             flag_we;
    logic             lut_we;
    logic [IDX_W-1:0] lut_addr;
    logic [OFF_W-1:0] lut_data;
    logic [PC_W-1:0]  pc;
    logic             flag;
    logic             running;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output start, halt, branch_en, branch_sel, target_idx, alu_overflow,
               flag_we, lut_we, lut_addr, lut_data,
        input  pc, flag, running, done, state_dbg
    );

    modport slave (
        input  start, halt, branch_en, branch_sel, target_idx, alu_overflow,
               flag_we, lut_we, lut_addr, lut_data,
        output pc, flag, running, done, state_dbg
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter / next-PC stage: run/halt sequencing, condition flag and
// BNO/BOF branches resolved through a register-based signed-offset LUT.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 8,
    parameter int LUT_DEPTH = 16
) (
    input logic    clk,
    input logic    reset,
    fetch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic            flag_q;
    logic            running_q;
    logic            done_q;
    logic [OFF_W-1:0] lut [LUT_DEPTH];

    logic [OFF_W-1:0] off_raw;
    logic [PC_W-1:0]  off_ext;
    logic             taken;

    // BNO takes when flag is clear, BOF when set: branch_sel simply names the wanted flag value.
    always_comb begin
        off_raw = lut[bus.target_idx];
        off_ext = {{(PC_W-OFF_W){off_raw[OFF_W-1]}}, off_raw};
        taken   = bus.branch_en && (bus.branch_sel == flag_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            flag_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
        end else begin
            // The branch above already read the old flag, so a same-edge update is only seen next cycle.
            if (bus.flag_we) flag_q <= bus.alu_overflow;

            if (bus.lut_we && state != RUN) lut[bus.lut_addr] <= bus.lut_data;

            case (state)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pc_q      <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        state     <= HALTED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (taken) begin
                        pc_q <= pc_q + off_ext;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pc_q      <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flag      = flag_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against an arithmetic reference model.
module tb_fetch_unit;
    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int MOD   = 1 << PC_W;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_if #(.PC_W(PC_W), .OFF_W(OFF_W), .IDX_W(4)) bus ();

    fetch_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .LUT_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pc as an integer, run/halt as two booleans, LUT as signed ints.
    int m_pc;
    bit m_flag;
    bit m_run;
    bit m_halted;
    int m_lut [16];

    function automatic int wrap(int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_flag = 0; m_run = 0; m_halted = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;
    endfunction

    function automatic void model_edge();
        int  nxt_pc;
        bit  want;
        int  v;
        nxt_pc = m_pc;
        if (m_run) begin
            want = bus.branch_sel;
            if (bus.halt) begin
                m_run = 0; m_halted = 1;
            end else if (bus.branch_en && (m_flag == want)) begin
                nxt_pc = wrap(m_pc + m_lut[bus.target_idx]);
            end else begin
                nxt_pc = wrap(m_pc + 1);
            end
        end else begin
            if (bus.lut_we) begin
                v = int'(bus.lut_data);
                if (v >= 128) v = v - 256;
                m_lut[bus.lut_addr] = v;
            end
            if (bus.start) begin
                m_run = 1; m_halted = 0; nxt_pc = 0;
            end
        end
        if (bus.flag_we) m_flag = bus.alu_overflow;
        m_pc = nxt_pc;
    endfunction

    task automatic check(string tag);
        checks++;
        assert (bus.pc === PC_W'(m_pc)) else begin
            errors++; $error("FAIL %s pc: got %0d expected %0d", tag, bus.pc, m_pc);
        end
        checks++;
        assert (bus.flag === m_flag) else begin
            errors++; $error("FAIL %s flag: got %0b expected %0b", tag, bus.flag, m_flag);
        end
        checks++;
        assert (bus.running === m_run) else begin
            errors++; $error("FAIL %s running: got %0b expected %0b", tag, bus.running, m_run);
        end
        checks++;
        assert (bus.done === m_halted) else begin
            errors++; $error("FAIL %s done: got %0b expected %0b", tag, bus.done, m_halted);
        end
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.halt = 0; bus.branch_en = 0; bus.branch_sel = 0;
        bus.target_idx = 0; bus.alu_overflow = 0; bus.flag_we = 0;
        bus.lut_we = 0; bus.lut_addr = 0; bus.lut_data = 0;
    endtask

    // Called #1 after a rising edge; inputs already set for the coming edge.
    task automatic step(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check(tag);
        clear_inputs();
    endtask

    task automatic do_reset(string tag);
        clear_inputs();
        reset = 1'b1;
        #2;
        model_reset();
        check(tag);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_release"});
    endtask

    task automatic run_to(int target);
        int n;
        n = 0;
        while (m_pc != target && n < 2000) begin
            step("run_to");
            n++;
        end
        checks++;
        assert (n < 2000) else begin
            errors++; $error("FAIL run_to: never reached pc %0d (pc=%0d)", target, bus.pc);
        end
    endtask

    task automatic lut_write(int addr, logic [OFF_W-1:0] data);
        bus.lut_we = 1; bus.lut_addr = 4'(addr); bus.lut_data = data;
        step("lut_write");
    endtask

    task automatic branch(bit sel, int idx, string tag);
        bus.branch_en = 1; bus.branch_sel = sel; bus.target_idx = 4'(idx);
        step(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        do_reset("reset");

        // Start, then count up through idle instructions.
        bus.start = 1; step("start");
        for (int i = 0; i < 5; i++) step("count");
        do_reset("reset_run");
        bus.start = 1; step("restart");
        for (int i = 0; i < 3; i++) step("count3");
        // Asynchronous abort mid-run at pc=3.
        do_reset("async_abort");

        lut_write(2, 8'hFC);
        lut_write(1, 8'h05);
        lut_write(0, 8'h80);
        lut_write(3, 8'h02);
        bus.start = 1; step("start2");
        run_to(10);
        branch(0, 2, "bno_taken");
        run_to(10);
        branch(1, 2, "bof_not_taken");

        run_to(20);
        bus.flag_we = 1; bus.alu_overflow = 1;
        branch(1, 1, "bof_old_flag");
        branch(1, 1, "bof_new_flag");

        run_to(1023);
        step("wrap_up");
        run_to(2);
        branch(1, 0, "wrap_down");

        // Zero offset self-loop through an entry still at its reset value.
        branch(1, 4, "self_loop1");
        branch(1, 4, "self_loop2");

        run_to(40);
        bus.halt = 1;
        branch(1, 1, "halt_wins");
        step("halted_hold");
        lut_write(5, 8'h33);
        bus.start = 1; step("restart_halted");

        bus.lut_we = 1; bus.lut_addr = 3; bus.lut_data = 8'h10;
        step("lut_we_in_run");
        run_to(50);
        branch(1, 3, "lut_unchanged");
        branch(1, 5, "lut_halted_write");
        branch(0, 5, "bno_flag_set");

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            bus.start        = ($urandom_range(0, 7) == 0);
            bus.halt         = ($urandom_range(0, 24) == 0);
            bus.branch_en    = $urandom_range(0, 1);
            bus.branch_sel   = $urandom_range(0, 1);
            bus.target_idx   = 4'($urandom_range(0, 15));
            bus.flag_we      = $urandom_range(0, 1);
            bus.alu_overflow = $urandom_range(0, 1);
            bus.lut_we       = $urandom_range(0, 1);
            bus.lut_addr     = 4'($urandom_range(0, 15));
            bus.lut_data     = 8'($urandom_range(0, 255));
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and next-PC stage for the 8-bit accumulator core. Sits upstream of the ALU: drives the instruction ROM address each cycle.
- Latches the ALU overflow/condition flag and resolves the B-type branches BNO (branch if no overflow) and BOF (branch if overflow) through a 16-entry signed-offset lookup table.
- Owns run/halt sequencing: start, HALT, done.

Parameters:
- PC_W, 10, program counter width in bits; the PC wraps modulo 2^PC_W.
- OFF_W, 8, width of each branch-offset LUT entry; two's complement, sign-extended to PC_W.
- LUT_DEPTH, 16, number of offset LUT entries; index width is log2(LUT_DEPTH) = 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse that begins program execution at PC 0.
- halt  in  1  decoded HALT instruction (A-type func 3'b111) for the current PC.
- branch_en  in  1  current instruction is a B-type branch.
- branch_sel  in  1  0 = BNO, 1 = BOF.
- target_idx  in  4  offset LUT index taken from the branch instruction.
- alu_overflow  in  1  overflow/condition output of the ALU.
- flag_we  in  1  capture alu_overflow into the flag register this cycle.
- lut_we  in  1  offset LUT write enable.
- lut_addr  in  4  offset LUT write address.
- lut_data  in  OFF_W  offset LUT write data.
- pc  out  PC_W  instruction ROM address.
- flag  out  1  latched condition flag.
- running  out  1  high in RUN.
- done  out  1  high in HALTED.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, pc=0, flag=0, running=0, done=0, all LUT entries=0. Reset asserted mid-RUN aborts immediately; a branch in flight is discarded.
- States:
  - IDLE: pc held at 0. start -> RUN (pc stays 0).
  - RUN: see the per-cycle rules below.
  - HALTED: pc frozen at the HALT address; done=1. start -> RUN with pc=0 and done=0 on the next edge.
- running=(state==RUN) and done=(state==HALTED); both are registered state decodes with no combinational path from the inputs.
- RUN, per cycle, in priority order:
  1. halt=1 -> next state HALTED, pc unchanged.
  2. Branch taken, defined as branch_en=1 and ((branch_sel=0 and flag=0) or (branch_sel=1 and flag=1)) -> pc <= pc + sext(LUT[target_idx]).
  3. Otherwise -> pc <= pc + 1.
- Arithmetic is modulo 2^PC_W for both pc+1 and pc+offset. Wrap-around past the maximum or below 0 is legal and silent.
- An offset of 0 is a legal self-loop: pc holds while the branch stays taken.
- flag update: on an edge with flag_we=1, flag <= alu_overflow, in any state. A branch evaluated on that same edge uses the old flag value, so the new flag is visible to the next instruction.
- halt and branch_en asserted together: halt wins and no pc change occurs.
- halt, branch_en and flag-driven control are ignored in IDLE and HALTED. start is ignored in RUN.
- LUT writes (lut_we=1) are accepted only in IDLE and HALTED; they are ignored in RUN.
  - A write to entry k and a branch reading entry k never coincide, because branches are only evaluated in RUN.
- Latency: pc changes one cycle after the controlling input is sampled. There is no pipeline bubble, and a taken branch costs one cycle.
- The LUT is implemented as registers (LUT_DEPTH x OFF_W) with an asynchronous read.

Test Plan:
- Reset, then a start pulse, 5 idle cycles -> pc steps 0,1,2,3,4,5 and running=1. Assert reset at pc=3 -> pc=0 and state IDLE in the same cycle, without waiting for a clock edge.
- In IDLE write LUT[2]=8'hFC (-4). In RUN at pc=10 with flag=0, branch_en=1, branch_sel=0, target_idx=2 -> pc=6. Repeat at pc=10 with branch_sel=1 -> pc=11 (branch not taken).
- At pc=20, flag_we=1 and alu_overflow=1 on the same edge as a BOF (LUT[1]=8'h05) -> pc=21 (old flag used). Next cycle, the same BOF -> pc=26.
- PC_W=10, pc=1023, no branch -> pc=0. At pc=2 with LUT[0]=8'h80 (-128) and the branch taken -> pc=898.
- halt=1 and a taken branch in the same cycle at pc=40 -> state HALTED, pc=40, done=1. An lut_we write in HALTED updates the entry. Then start -> pc=0, done=0, running=1.
- lut_we=1 in RUN with LUT[3]=8'h02 beforehand, writing 8'h10 -> entry unchanged; a later taken branch through index 3 from pc=50 -> pc=52.
